// File: rtl/nmi_apb_pkg.sv
// Shared definitions for the APB-to-NMI bridge: FSM encoding and timeout default.
package nmi_apb_pkg;

  // Bridge FSM states; encoding is visible on debug taps, keep it fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } nmi_state_e;

  // Default number of cycles the bridge waits for m_nmi_ready.
  localparam int NMI_TIMEOUT_DEF = 16;

  // Width of the wait counter; TIMEOUT is limited to 2..255.
  localparam int NMI_CNT_W = 8;

  // Terminal count for a given timeout: the last cycle valid may be held.
  function automatic logic [NMI_CNT_W-1:0] nmi_last_cnt(input int timeout);
    return NMI_CNT_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/nmi_timeout_cnt.sv
// Wait-cycle counter for an outstanding NMI request; flags the last allowed cycle.
module nmi_timeout_cnt
  import nmi_apb_pkg::*;
#(
  parameter int TIMEOUT = NMI_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [NMI_CNT_W-1:0] cnt;

  // Count REQ cycles without a handshake; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (!rstn)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == nmi_last_cnt(TIMEOUT));

endmodule

// File: rtl/apb2nmi_bridge.sv
// APB slave to NMI master bridge: one NMI request per APB transfer, with timeout.
module apb2nmi_bridge
  import nmi_apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = NMI_TIMEOUT_DEF,
  parameter int WSTRB_WIDTH = (DATA_WIDTH - 1) / 8 + 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  // APB slave
  input  logic                   s_apb_psel,
  input  logic                   s_apb_penable,
  input  logic                   s_apb_pwrite,
  input  logic [ADDR_WIDTH-1:0]  s_apb_paddr,
  input  logic [DATA_WIDTH-1:0]  s_apb_pwdata,
  input  logic [WSTRB_WIDTH-1:0] s_apb_pstrb,
  output logic                   s_apb_pready,
  output logic [DATA_WIDTH-1:0]  s_apb_prdata,
  output logic                   s_apb_pslverr,
  // NMI master
  output logic                   m_nmi_valid,
  output logic                   m_nmi_instr,
  input  logic                   m_nmi_ready,
  output logic [ADDR_WIDTH-1:0]  m_nmi_addr,
  output logic [DATA_WIDTH-1:0]  m_nmi_wdata,
  output logic [WSTRB_WIDTH-1:0] m_nmi_wstrb,
  input  logic [DATA_WIDTH-1:0]  m_nmi_rdata
);

  nmi_state_e             state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [WSTRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0]  prdata_q;
  logic                   wr_q;
  logic                   err_q;
  logic                   valid_q;
  logic                   pready_q;

  logic setup;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_exp;

  // APB setup phase seen while idle starts a new NMI request.
  assign setup   = s_apb_psel && !s_apb_penable;
  assign cnt_clr = (state == IDLE) && setup;
  // Stop counting once expired so the counter never wraps.
  assign cnt_en  = (state == REQ) && !m_nmi_ready && !cnt_exp;

  nmi_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (cnt_clr),
    .enable  (cnt_en),
    .expired (cnt_exp)
  );

  // Bridge FSM with registered payload, read data and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      prdata_q <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      pready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            addr_q   <= s_apb_paddr;
            wdata_q  <= s_apb_pwdata;
            // Reads present an all-zero strobe to the NMI slave.
            wstrb_q  <= s_apb_pwrite ? s_apb_pstrb : '0;
            wr_q     <= s_apb_pwrite;
            prdata_q <= '0;
            valid_q  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (m_nmi_ready) begin
            prdata_q <= wr_q ? '0 : m_nmi_rdata;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            pready_q <= 1'b1;
            state    <= RESP;
          end else if (cnt_exp) begin
            // Slave never answered: abandon the request and report an error.
            prdata_q <= '0;
            err_q    <= 1'b1;
            valid_q  <= 1'b0;
            pready_q <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          // Completed access phase or an aborted transfer both return to idle.
          if (!s_apb_psel || s_apb_penable) begin
            pready_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          valid_q  <= 1'b0;
          pready_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign s_apb_pready  = pready_q;
  assign s_apb_pslverr = pready_q && err_q;
  assign s_apb_prdata  = prdata_q;
  assign m_nmi_valid   = valid_q;
  assign m_nmi_instr   = 1'b0;
  assign m_nmi_addr    = addr_q;
  assign m_nmi_wdata   = wdata_q;
  assign m_nmi_wstrb   = wstrb_q;

endmodule

// File: tb/tb_apb2nmi_bridge.sv
// Randomized bench for apb2nmi_bridge: APB master, NMI memory slave, transaction model.
module tb_apb2nmi_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [SW-1:0] pstrb = '0;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;
  logic          m_nmi_valid, m_nmi_instr;
  logic          m_nmi_ready = 1'b0;
  logic [AW-1:0] m_nmi_addr;
  logic [DW-1:0] m_nmi_wdata;
  logic [SW-1:0] m_nmi_wstrb;
  logic [DW-1:0] m_nmi_rdata = '0;

  always #5 clk = ~clk;

  apb2nmi_bridge #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .TIMEOUT (TMO), .WSTRB_WIDTH (SW)
  ) dut (
    .clk (clk), .rstn (rstn),
    .s_apb_psel (psel), .s_apb_penable (penable), .s_apb_pwrite (pwrite),
    .s_apb_paddr (paddr), .s_apb_pwdata (pwdata), .s_apb_pstrb (pstrb),
    .s_apb_pready (pready), .s_apb_prdata (prdata), .s_apb_pslverr (pslverr),
    .m_nmi_valid (m_nmi_valid), .m_nmi_instr (m_nmi_instr), .m_nmi_ready (m_nmi_ready),
    .m_nmi_addr (m_nmi_addr), .m_nmi_wdata (m_nmi_wdata), .m_nmi_wstrb (m_nmi_wstrb),
    .m_nmi_rdata (m_nmi_rdata)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d, input bit [3:0] s);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Reference model: word memory as the APB master sees it.
  bit [31:0] model_mem [int];
  // NMI slave memory, written only through the bridge's payload.
  bit [31:0] slave_mem [int];

  int            slv_delay = 0;
  int            vcnt = 0;
  int            pulses = 0;
  int            vcycles = 0;
  bit            in_req = 1'b0;
  bit            unstable = 1'b0;
  logic [AW-1:0] snap_addr;
  logic [DW-1:0] snap_wdata;
  logic [SW-1:0] snap_wstrb;

  // NMI slave: answers after slv_delay valid cycles, tracks pulses and payload stability.
  always @(negedge clk) begin
    if (m_nmi_valid) begin
      if (!in_req) begin
        in_req = 1'b1;
        vcnt = 0;
        pulses++;
        snap_addr = m_nmi_addr;
        snap_wdata = m_nmi_wdata;
        snap_wstrb = m_nmi_wstrb;
      end else if (m_nmi_addr !== snap_addr || m_nmi_wdata !== snap_wdata ||
                   m_nmi_wstrb !== snap_wstrb) begin
        unstable = 1'b1;
      end
      vcycles++;
      if (vcnt == slv_delay) begin
        m_nmi_ready = 1'b1;
        m_nmi_rdata = slave_mem.exists(int'(m_nmi_addr)) ? slave_mem[int'(m_nmi_addr)] : '0;
        if (m_nmi_wstrb != '0)
          slave_mem[int'(m_nmi_addr)] = merge(m_nmi_rdata, m_nmi_wdata, m_nmi_wstrb);
      end else begin
        m_nmi_ready = 1'b0;
        m_nmi_rdata = $urandom;
      end
      vcnt++;
    end else begin
      in_req = 1'b0;
      m_nmi_ready = 1'b0;
      m_nmi_rdata = $urandom;
    end
  end

  // One APB transfer; leaves psel/penable driven so the caller can go back-to-back.
  task automatic xfer(input string tag, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input int dly);
    int   p0, c0, waits, waits_exp;
    bit   err_exp, done;
    logic [31:0] rd_exp, old;
    slv_delay = dly;
    p0 = pulses;
    c0 = vcycles;
    unstable = 1'b0;
    err_exp = (dly >= TMO);
    waits_exp = err_exp ? TMO : dly + 1;
    old = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 32'h0;
    rd_exp = (err_exp || wr) ? 32'h0 : old;
    if (wr && !err_exp) model_mem[int'(a)] = merge(old, d, s);

    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1 penable = 1'b1;
    waits = 0;
    done = 1'b0;
    for (int i = 0; i < TMO + 8 && !done; i++) begin
      @(negedge clk);
      if (pready) done = 1'b1;
      else waits++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_waits"}, 64'(waits), 64'(waits_exp));
    chk({tag, "_pslverr"}, 64'(pslverr), 64'(err_exp));
    chk({tag, "_prdata"}, 64'(prdata), 64'(rd_exp));
    chk({tag, "_pulses"}, 64'(pulses - p0), 64'd1);
    chk({tag, "_vcycles"}, 64'(vcycles - c0), 64'(waits_exp));
    chk({tag, "_addr"}, 64'(snap_addr), 64'(a));
    chk({tag, "_wstrb"}, 64'(snap_wstrb), 64'(wr ? s : 4'h0));
    if (wr) chk({tag, "_wdata"}, 64'(snap_wdata), 64'(d));
    chk({tag, "_stable"}, 64'(unstable), 64'd0);
    chk({tag, "_instr"}, 64'(m_nmi_instr), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(m_nmi_valid), 64'd0);
    chk("rst_pready", 64'(pready), 64'd0);
    chk("rst_pslverr", 64'(pslverr), 64'd0);
    chk("rst_prdata", 64'(prdata), 64'd0);
    chk("rst_addr", 64'(m_nmi_addr), 64'd0);
    chk("rst_wdata", 64'(m_nmi_wdata), 64'd0);
    chk("rst_wstrb", 64'(m_nmi_wstrb), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    idle(2);

    // Directed cases
    xfer("wr_basic", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    idle(1);
    xfer("rd_basic", 1'b0, 32'h10, 32'h0, 4'hF, 0);
    idle(1);
    xfer("rd_delay3", 1'b0, 32'h10, 32'h0, 4'h0, 3);
    idle(1);
    xfer("rd_timeout", 1'b0, 32'h10, 32'h0, 4'h0, 1000);
    idle(1);
    xfer("wr_edge_last", 1'b1, 32'h14, 32'h12345678, 4'h5, TMO - 1);
    idle(1);
    xfer("wr_edge_tmo", 1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, TMO);
    idle(1);
    xfer("rd_edge", 1'b0, 32'h14, 32'h0, 4'h0, 1);
    idle(1);

    // Reset pulsed while a request is outstanding
    slv_delay = 1000;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hBAD0BAD0; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk);
    chk("rstmid_valid_pre", 64'(m_nmi_valid), 64'd1);
    @(posedge clk); #1 rstn = 1'b1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", 64'(m_nmi_valid), 64'd0);
    chk("rstmid_pready", 64'(pready), 64'd0);
    chk("rstmid_wstrb", 64'(m_nmi_wstrb), 64'd0);
    @(posedge clk); #1;
    xfer("rstmid_wr", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0);
    idle(1);
    xfer("rstmid_rd", 1'b0, 32'h20, 32'h0, 4'h0, 0);
    idle(1);

    // Back-to-back write then read with psel held high
    p0 = pulses;
    xfer("b2b_wr", 1'b1, 32'h24, 32'hA5A5_5A5A, 4'hF, 0);
    xfer("b2b_rd", 1'b0, 32'h24, 32'h0, 4'h0, 0);
    chk("b2b_pulses", 64'(pulses - p0), 64'd2);
    idle(1);

    // Randomized traffic over a small address window
    for (int n = 0; n < 40; n++) begin
      bit   wr;
      int   r, dly;
      logic [31:0] a, d;
      logic [3:0] s;
      wr = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 7) * 4);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      if (r < 6)      dly = $urandom_range(0, 4);
      else if (r < 8) dly = TMO - 1 + $urandom_range(0, 1);
      else            dly = $urandom_range(TMO + 1, TMO + 5);
      xfer($sformatf("rnd%0d", n), wr, a, d, s, dly);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
